ps2_key_decoder: RTL

Receives PS/2 keyboard frames and converts the left-arrow, right-arrow and spacebar scancodes into the 2-bit `key` code used by the game state machine (01 left, 10 right, 11 spacebar, 00 none). It sits between the board PS/2 pins and the game control logic. It emits exactly one single-cycle key event per physical key press, with typematic repeats and break codes suppressed.

---
 rtl/skyhop_pkg.sv | 24 ++
 rtl/ps2_rx.sv | 126 ++++++++++++
 rtl/ps2_key_decoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/skyhop_pkg.sv
// Shared constants and state encodings for the PS/2 key decoder.
// Key codes match the game state machine's 2-bit key input.
package skyhop_pkg;

  localparam logic [1:0] K_NONE     = 2'b00;
  localparam logic [1:0] K_LEFT     = 2'b01;
  localparam logic [1:0] K_RIGHT    = 2'b10;
  localparam logic [1:0] K_SPACEBAR = 2'b11;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Bit positions in the held-key vector
  localparam int unsigned HELD_LEFT  = 0;
  localparam int unsigned HELD_RIGHT = 1;
  localparam int unsigned HELD_SPACE = 2;

  typedef enum logic [1:0] {ScBase, ScExt, ScBrk, ScExtBrk} sc_state_e;
  typedef enum logic {RxIdle, RxShift} rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock debounce filter, frame FSM and timeout.
// byte_valid and rx_error are combinational strobes aligned with the sampling fall strobe.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_rx_error
);
  import skyhop_pkg::*;

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYC + 1);

  logic             r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic [FiltW-1:0] r_filt_cnt;
  logic             r_filt_lvl, r_fall;
  logic [ToW-1:0]   r_to_cnt;
  rx_state_e        r_state, w_state_d;
  logic [3:0]       r_bit_cnt, w_bit_cnt_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_par, w_par_d;
  logic             w_flip, w_byte_valid, w_rx_error;

  // Level changes only after FILTER_LEN consecutive samples disagree with it
  assign w_flip = (r_clk_sync != r_filt_lvl) && (r_filt_cnt == FiltW'(FILTER_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_filt_cnt <= '0;
      r_filt_lvl <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_data;
      r_dat_sync <= r_dat_meta;
      r_fall     <= w_flip & r_filt_lvl;
      if (w_flip) begin
        r_filt_lvl <= r_clk_sync;
        r_filt_cnt <= '0;
      end else if (r_clk_sync != r_filt_lvl) begin
        r_filt_cnt <= r_filt_cnt + FiltW'(1);
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt  <= '0;
      r_state   <= RxIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else begin
      if (r_fall) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != ToW'(TIMEOUT_CYC)) begin
        r_to_cnt <= r_to_cnt + ToW'(1);
      end
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_par     <= w_par_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_par_d      = r_par;
    w_byte_valid = 1'b0;
    w_rx_error   = 1'b0;
    case (r_state)
      RxIdle: begin
        if (r_fall) begin
          if (!r_dat_sync) begin
            w_state_d   = RxShift;
            w_bit_cnt_d = '0;
          end else begin
            w_rx_error = 1'b1;
          end
        end
      end
      RxShift: begin
        if (r_fall) begin
          if (r_bit_cnt < 4'd8) begin
            w_shift_d   = {r_dat_sync, r_shift[7:1]};
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end else if (r_bit_cnt == 4'd8) begin
            w_par_d     = r_dat_sync;
            w_bit_cnt_d = 4'd9;
          end else begin
            w_state_d = RxIdle;
            if ((^{r_shift, r_par}) && r_dat_sync) begin
              w_byte_valid = 1'b1;
            end else begin
              w_rx_error = 1'b1;
            end
          end
        end else if (r_to_cnt == ToW'(TIMEOUT_CYC - 1)) begin
          w_rx_error = 1'b1;
          w_state_d  = RxIdle;
        end
      end
      default: w_state_d = RxIdle;
    endcase
  end

  assign o_byte_data  = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_rx_error   = w_rx_error;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 arrow/space scancodes into one-cycle game key events.
// Typematic repeats and break codes are swallowed via per-key held flags.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [1:0] o_key,
  output logic       o_frame_error
);
  import skyhop_pkg::*;

  logic [7:0] w_byte;
  logic       w_byte_valid, w_rx_error;
  sc_state_e  r_sc_state, w_sc_state_d;
  logic [2:0] r_held, w_held_d, w_make, w_break, w_new;
  logic [1:0] r_key, w_key_d;
  logic       r_frame_error;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_byte_data (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_rx_error  (w_rx_error)
  );

  always_comb begin
    w_sc_state_d = r_sc_state;
    w_make       = '0;
    w_break      = '0;
    if (w_rx_error) begin
      w_sc_state_d = ScBase;
    end else if (w_byte_valid) begin
      case (r_sc_state)
        ScBase: begin
          if (w_byte == SC_E0)         w_sc_state_d = ScExt;
          else if (w_byte == SC_F0)    w_sc_state_d = ScBrk;
          else if (w_byte == SC_SPACE) w_make[HELD_SPACE] = 1'b1;
        end
        ScExt: begin
          if (w_byte == SC_F0) begin
            w_sc_state_d = ScExtBrk;
          end else begin
            w_sc_state_d = ScBase;
            if (w_byte == SC_LEFT)       w_make[HELD_LEFT]  = 1'b1;
            else if (w_byte == SC_RIGHT) w_make[HELD_RIGHT] = 1'b1;
          end
        end
        ScBrk: begin
          w_sc_state_d = ScBase;
          if (w_byte == SC_SPACE) w_break[HELD_SPACE] = 1'b1;
        end
        ScExtBrk: begin
          w_sc_state_d = ScBase;
          if (w_byte == SC_LEFT)       w_break[HELD_LEFT]  = 1'b1;
          else if (w_byte == SC_RIGHT) w_break[HELD_RIGHT] = 1'b1;
        end
        default: w_sc_state_d = ScBase;
      endcase
    end
  end

  // A make on an already-held key is a typematic repeat and produces no event
  assign w_new    = w_make & ~r_held;
  assign w_held_d = (r_held | w_make) & ~w_break;

  always_comb begin
    w_key_d = K_NONE;
    if (w_new[HELD_LEFT])       w_key_d = K_LEFT;
    else if (w_new[HELD_RIGHT]) w_key_d = K_RIGHT;
    else if (w_new[HELD_SPACE]) w_key_d = K_SPACEBAR;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sc_state    <= ScBase;
      r_held        <= '0;
      r_key         <= K_NONE;
      r_frame_error <= 1'b0;
    end else begin
      r_sc_state    <= w_sc_state_d;
      r_held        <= w_held_d;
      r_key         <= w_key_d;
      r_frame_error <= w_rx_error;
    end
  end

  assign o_key         = r_key;
  assign o_frame_error = r_frame_error;

endmodule
